// File: rtl/accum_pkg.sv
// Shared types and helpers for the windowed accumulator.
// Holds the FSM state encoding, overflow mode constants and counter sizing.
package accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Counter must reach WINDOW itself, hence the +1.
    function automatic int cnt_width(input int window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/sat_adder.sv
// Combinational accumulate step: acc + zero-extended sample, wrapping or
// saturating at ACC_W bits and flagging any carry out of the accumulator.
module sat_adder
    import accum_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 6
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] sample,
    input  logic              sat_mode,
    output logic [ACC_W-1:0]  result,
    output logic              ovf
);

    logic [ACC_W:0] w_sum;

    assign w_sum  = {1'b0, acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, sample};
    assign ovf    = w_sum[ACC_W];
    assign result = !w_sum[ACC_W]       ? w_sum[ACC_W-1:0] :
                    (sat_mode == MODE_WRAP) ? w_sum[ACC_W-1:0] :
                                          {ACC_W{1'b1}};

endmodule

// File: rtl/accum_window.sv
// Windowed accumulator: sums WINDOW samples into one result word with valid/ready on both sides.
// Build macro ACCUM_AVG_EN presents the truncated mean (WINDOW must then be a power of two).
module accum_window
    import accum_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 6,
    parameter int WINDOW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              sat_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic [ACC_W-1:0]  run_sum
);

    localparam int CNT_W = cnt_width(WINDOW);

    if (WINDOW < 1) begin : g_bad_window
        $error("accum_window: WINDOW must be at least 1");
    end

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_sum;
    logic               r_out_ovf;

    logic               w_accept;
    logic               w_last;
    logic [ACC_W-1:0]   w_add_result;
    logic               w_add_ovf;
    logic               w_ovf_next;
    logic [ACC_W-1:0]   w_final_sum;

    sat_adder #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_sat_adder (
        .acc      (r_acc),
        .sample   (in_data),
        .sat_mode (sat_mode),
        .result   (w_add_result),
        .ovf      (w_add_ovf)
    );

`ifdef ACCUM_AVG_EN
    localparam int SHIFT = $clog2(WINDOW);

    if ((WINDOW & (WINDOW - 1)) != 0) begin : g_avg_needs_pow2
        $error("accum_window: ACCUM_AVG_EN requires WINDOW to be a power of two");
    end

    assign w_final_sum = w_add_result >> SHIFT;
`else
    assign w_final_sum = w_add_result;
`endif

    // No path from out_ready: a freed slot is only visible after the handshake edge.
    assign in_ready   = !clear && (r_state != HOLD);
    assign w_accept   = in_valid && in_ready;
    assign w_last     = (r_cnt == CNT_W'(WINDOW - 1));
    assign w_ovf_next = r_ovf | w_add_ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
        end else if (clear) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_add_result;
                        r_ovf <= w_ovf_next;
                        if (w_last) begin
                            r_state     <= HOLD;
                            r_cnt       <= CNT_W'(WINDOW);
                            r_out_valid <= 1'b1;
                            r_out_sum   <= w_final_sum;
                            r_out_ovf   <= w_ovf_next;
                        end else begin
                            r_state <= ACCUM;
                            r_cnt   <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (r_out_valid && out_ready) begin
                        r_state     <= IDLE;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_ovf   = r_out_ovf;
    assign run_sum   = r_acc;

endmodule

// File: doc/accum_window.md
Name: accum_window

Overview:
- Parameterised windowed accumulator: sums WINDOW unsigned input samples and presents the total as one result word.
- Input and output each use a valid/ready handshake, so the block can sit between a sample producer and a downstream consumer.
- Adds a wrap/saturate mode, an overflow flag, a synchronous clear and output backpressure.

Parameters:
DATA_W, 4, input sample width in bits (>=1)
ACC_W, 6, accumulator and result width in bits (>= DATA_W)
WINDOW, 4, samples per result (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
clear  input  1  synchronous clear; abandons the current window and any held result
sat_mode  input  1  0 = wrap on overflow, 1 = saturate at 2^ACC_W-1
in_valid  input  1  in_data is valid
in_ready  output  1  block accepts a sample this cycle
in_data  input  DATA_W  unsigned sample
out_valid  output  1  out_sum/out_ovf hold a completed result
out_ready  input  1  consumer takes the result
out_sum  output  ACC_W  completed window sum
out_ovf  output  1  an overflow occurred in this window
run_sum  output  ACC_W  live accumulator register value (debug)

Behaviour:
- Reset values (asynchronous): state=IDLE, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_ovf=0, run_sum=0.
- A sample is accepted in a cycle where in_valid && in_ready.
- in_ready = !clear && state != HOLD. It is a pure function of registered state and clear, with no path from out_ready.
- States:
  - IDLE: cnt==0, acc==0.
  - ACCUM: 0 < cnt < WINDOW.
  - HOLD: result held on the output.
- Transitions:
  - IDLE -> ACCUM on accept.
  - IDLE -> HOLD on accept when WINDOW==1.
  - ACCUM -> HOLD on the accept that makes cnt==WINDOW.
  - HOLD -> IDLE when out_valid && out_ready.
- Arithmetic on each accept:
  - sum = acc + zero-extended in_data, computed at ACC_W+1 bits.
  - If sum[ACC_W]=1: wrap mode keeps sum[ACC_W-1:0]; saturate mode keeps all-ones. In both modes ovf is set and stays set until the window ends.
  - sat_mode is sampled per accept, so a mid-window change applies from the next accept.
- Latency: out_valid rises on the clock edge that accepts the WINDOW-th sample, i.e. it is visible the cycle after that accept. out_sum and out_ovf are registered on that same edge.
- HOLD:
  - out_sum, out_ovf and out_valid stay stable while out_ready=0.
  - In the handshake cycle, the next edge clears out_valid, acc, cnt and ovf.
  - in_ready returns to 1 the cycle after the handshake; there is no same-cycle bypass.
- run_sum tracks acc every cycle. In HOLD, acc keeps the final value until the handshake.
- cnt is $clog2(WINDOW+1) bits wide and never exceeds WINDOW.
- clear:
  - Next edge returns to IDLE with acc/cnt/ovf/out_valid/out_sum/out_ovf = 0.
  - A sample presented in a clear cycle is not accepted, because in_ready=0.
  - clear overrides a simultaneous output handshake.
- reset asserted at any point, including HOLD, forces the reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: ACCUM_AVG_EN.
- Defined:
  - out_sum = final window sum >> $clog2(WINDOW), i.e. the truncated mean.
  - WINDOW must be a power of two; an elaboration-time check fails otherwise.
  - run_sum still shows the raw acc.
- Undefined: out_sum = the raw window sum. No WINDOW restriction.

Decomposition:
- Package accum_pkg:
  - state enum typedef (IDLE, ACCUM, HOLD).
  - mode constants MODE_WRAP=0, MODE_SAT=1.
  - clog2-based helper for cnt width.
- Sub-module sat_adder: combinational, parameterised DATA_W/ACC_W. Inputs acc, sample, sat_mode; outputs result and ovf.
- The FSM, counter and output registers stay in accum_window.

Test Plan:
- Defaults (DATA_W=4, ACC_W=6, WINDOW=4), out_ready=1, samples 1,2,3,4 back-to-back -> out_valid=1 for exactly one cycle, the cycle after the 4th accept; out_sum=10, out_ovf=0; in_ready=1 again two cycles after the 4th accept.
- ACC_W=5, samples 15,15,15,1:
  - sat_mode=0 -> out_sum=14, out_ovf=1.
  - Repeat with sat_mode=1 -> out_sum=31, out_ovf=1.
  - Next window 1,1,1,1 -> out_sum=4, out_ovf=0.
- Backpressure: out_ready=0 for 5 cycles after a result of 10 -> out_sum=10 stable, in_ready=0, in_valid=1 with data 9 not accepted. Then out_ready=1 -> out_valid low next cycle; the following window excludes the 9.
- Gapped input: in_valid pattern 1,0,1,0,0,1,1 with data 2,7,3,7,7,4,5 -> only 2,3,4,5 are accepted; out_sum=14.
- clear after samples 6,6 (run_sum=12) -> run_sum=0 next cycle. Then 5,5,5,5 -> out_sum=20. clear asserted while in HOLD -> out_valid=0 next cycle with no handshake.
- reset pulse mid-window and in HOLD -> out_valid, run_sum and out_sum are 0 before the next clock edge. With ACCUM_AVG_EN, samples 1,2,3,4 -> out_sum=2.
